threshold_multi: RTL and testbench

- Parametrised successor of the single-level pixel threshold stage in the video pipeline.
- Per channel, each pixel is compared against up to NLVL programmable thresholds. The selected mode decides the output: binary, inverted binary, band-pass, or multi-level quantisation through a per-channel output table.
- Threshold, level and mode settings are double-buffered and become active only at frame start.
- Tracks pixel position and emits start-of-frame and end-of-line flags aligned with the output data.

---
 rtl/threshold_multi_if.sv | 32 +++
 rtl/threshold_multi.sv | 248 ++++++++++++++++++++++++
 tb/tb_threshold_multi.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/threshold_multi_if.sv
// threshold_multi_if: pixel stream bundle for the threshold stage.
// The slave modport is the thresholding block; the master modport feeds
// pixels in and watches the processed stream come out.
interface threshold_multi_if #(
    parameter int CW  = 8,
    parameter int NCH = 3
);
    logic [NCH*CW-1:0] d_in;
    logic              d_in_vld;
    logic [NCH*CW-1:0] d_out;
    logic              d_out_vld;
    logic              d_out_sof;
    logic              d_out_eol;

    modport master (
        output d_in,
        output d_in_vld,
        input  d_out,
        input  d_out_vld,
        input  d_out_sof,
        input  d_out_eol
    );

    modport slave (
        input  d_in,
        input  d_in_vld,
        output d_out,
        output d_out_vld,
        output d_out_sof,
        output d_out_eol
    );
endinterface

// File: rtl/threshold_multi.sv
// threshold_multi: per-channel multi-level pixel threshold stage.
// Each channel is compared against NLVL programmable thresholds; the mode picks
// binary, inverted binary, band-pass or table-driven multi-level output.
// Tables and mode are double-buffered and swap in at the first pixel of a frame.
// Fixed 2-cycle latency, sof/eol flags travel with their pixel.
// Optional macro THRESHOLD_ROI_EN: adds a committed region-of-interest window;
// pixels outside the window pass through unchanged.
module threshold_multi #(
    parameter int CW   = 8,
    parameter int NCH  = 3,
    parameter int NLVL = 4,
    localparam int AW  = $clog2(NLVL + 1)
) (
    input  logic              clk,
    input  logic              reset,
    threshold_multi_if.slave  pix,
    input  logic [15:0]       input_res_x,
    input  logic [15:0]       input_res_y,
    input  logic              threshold_set,
    input  logic              threshold_t,
    input  logic [AW-1:0]     threshold_a,
    input  logic [NCH-1:0]    threshold_c,
    input  logic [NCH*CW-1:0] threshold_v,
    input  logic [1:0]        mode,
    input  logic              commit
`ifdef THRESHOLD_ROI_EN
    ,
    input  logic [15:0]       roi_x0,
    input  logic [15:0]       roi_x1,
    input  logic [15:0]       roi_y0,
    input  logic [15:0]       roi_y1
`endif
);

    typedef enum logic [1:0] {
        MODE_BIN   = 2'd0,
        MODE_INV   = 2'd1,
        MODE_BAND  = 2'd2,
        MODE_MULTI = 2'd3
    } mode_e;

    logic [CW-1:0] shadow_thr [NCH][NLVL];
    logic [CW-1:0] shadow_lvl [NCH][NLVL+1];
    logic [CW-1:0] active_thr [NCH][NLVL];
    logic [CW-1:0] active_lvl [NCH][NLVL+1];
    mode_e         active_mode;
    mode_e         eff_mode;
    logic          commit_pending;

    logic [15:0]   x_cnt, y_cnt;
    logic [15:0]   res_x_eff, res_y_eff;
    logic          last_x, last_y, at_origin, apply, in_roi;

    logic [NLVL-1:0] gt      [NCH];
    logic [CW-1:0]   lvl_sel [NCH];

    logic              s1_vld, s1_sof, s1_eol, s1_roi;
    logic [NCH*CW-1:0] s1_pix;
    logic [NCH-1:0]    s1_gt0, s1_gt1;
    logic [CW-1:0]     s1_lvl [NCH];
    mode_e             s1_mode;

    logic [NCH*CW-1:0] out_pix;
    logic [NCH*CW-1:0] out_data;
    logic              out_vld, out_sof, out_eol;

    function automatic logic [AW-1:0] popcount(input logic [NLVL-1:0] bits);
        logic [AW-1:0] sum;
        sum = '0;
        for (int i = 0; i < NLVL; i++) sum = sum + AW'(bits[i]);
        return sum;
    endfunction

    // A zero resolution behaves like a single pixel/line.
    assign res_x_eff = (input_res_x == 16'd0) ? 16'd1 : input_res_x;
    assign res_y_eff = (input_res_y == 16'd0) ? 16'd1 : input_res_y;
    assign last_x    = (x_cnt >= res_x_eff - 16'd1);
    assign last_y    = (y_cnt >= res_y_eff - 16'd1);
    assign at_origin = (x_cnt == 16'd0) && (y_cnt == 16'd0);
    // The frame's first pixel itself is processed with the freshly committed settings.
    assign apply     = pix.d_in_vld && commit_pending && at_origin;
    assign eff_mode  = apply ? mode_e'(mode) : active_mode;

    // Pixel position counters, stepped only by accepted pixels.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (pix.d_in_vld) begin
            if (last_x) begin
                x_cnt <= '0;
                y_cnt <= last_y ? 16'd0 : y_cnt + 16'd1;
            end else begin
                x_cnt <= x_cnt + 16'd1;
            end
        end
    end

    // Shadow table writes; threshold addresses beyond the table are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                for (int i = 0; i < NLVL; i++) shadow_thr[c][i] <= '0;
                for (int i = 0; i <= NLVL; i++) shadow_lvl[c][i] <= '0;
            end
        end else if (threshold_set) begin
            for (int c = 0; c < NCH; c++) begin
                if (threshold_c[c]) begin
                    for (int i = 0; i < NLVL; i++)
                        if (!threshold_t && threshold_a == AW'(i))
                            shadow_thr[c][i] <= threshold_v[c*CW +: CW];
                    for (int i = 0; i <= NLVL; i++)
                        if (threshold_t && threshold_a == AW'(i))
                            shadow_lvl[c][i] <= threshold_v[c*CW +: CW];
                end
            end
        end
    end

    // A commit arriving with the origin pixel stays pending for the next frame.
    always_ff @(posedge clk) begin
        if (reset)       commit_pending <= 1'b0;
        else if (commit) commit_pending <= 1'b1;
        else if (apply)  commit_pending <= 1'b0;
    end

    // Copy shadow settings into the active set at frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_mode <= MODE_BIN;
            for (int c = 0; c < NCH; c++) begin
                for (int i = 0; i < NLVL; i++) active_thr[c][i] <= '0;
                for (int i = 0; i <= NLVL; i++) active_lvl[c][i] <= '0;
            end
        end else if (apply) begin
            active_mode <= mode_e'(mode);
            active_thr  <= shadow_thr;
            active_lvl  <= shadow_lvl;
        end
    end

`ifdef THRESHOLD_ROI_EN
    logic [15:0] active_roi_x0, active_roi_x1, active_roi_y0, active_roi_y1;
    logic [15:0] eff_roi_x0, eff_roi_x1, eff_roi_y0, eff_roi_y1;

    // ROI window is double-buffered alongside the tables.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_roi_x0 <= '0;
            active_roi_x1 <= '0;
            active_roi_y0 <= '0;
            active_roi_y1 <= '0;
        end else if (apply) begin
            active_roi_x0 <= roi_x0;
            active_roi_x1 <= roi_x1;
            active_roi_y0 <= roi_y0;
            active_roi_y1 <= roi_y1;
        end
    end

    assign eff_roi_x0 = apply ? roi_x0 : active_roi_x0;
    assign eff_roi_x1 = apply ? roi_x1 : active_roi_x1;
    assign eff_roi_y0 = apply ? roi_y0 : active_roi_y0;
    assign eff_roi_y1 = apply ? roi_y1 : active_roi_y1;
    assign in_roi = (x_cnt >= eff_roi_x0) && (x_cnt <= eff_roi_x1) &&
                    (y_cnt >= eff_roi_y0) && (y_cnt <= eff_roi_y1);
`else
    assign in_roi = 1'b1;
`endif

    // Stage 1 compare: threshold hits per level, hit count and the level value it selects.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            gt[c]      = '0;
            lvl_sel[c] = '0;
            for (int i = 0; i < NLVL; i++)
                gt[c][i] = pix.d_in[c*CW +: CW] > (apply ? shadow_thr[c][i] : active_thr[c][i]);
            for (int i = 0; i <= NLVL; i++)
                if (popcount(gt[c]) == AW'(i))
                    lvl_sel[c] = apply ? shadow_lvl[c][i] : active_lvl[c][i];
        end
    end

    // Stage 1 register: everything stage 2 needs, so in-flight pixels keep their own settings.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_sof  <= 1'b0;
            s1_eol  <= 1'b0;
            s1_roi  <= 1'b0;
            s1_pix  <= '0;
            s1_gt0  <= '0;
            s1_gt1  <= '0;
            s1_mode <= MODE_BIN;
            for (int c = 0; c < NCH; c++) s1_lvl[c] <= '0;
        end else begin
            s1_vld <= pix.d_in_vld;
            s1_sof <= pix.d_in_vld && at_origin;
            s1_eol <= pix.d_in_vld && last_x;
            if (pix.d_in_vld) begin
                s1_pix  <= pix.d_in;
                s1_mode <= eff_mode;
                s1_roi  <= in_roi;
                for (int c = 0; c < NCH; c++) begin
                    s1_gt0[c] <= gt[c][0];
                    s1_gt1[c] <= gt[c][1];
                    s1_lvl[c] <= lvl_sel[c];
                end
            end
        end
    end

    // Stage 2 output selection by mode; pixels outside the ROI pass through.
    always_comb begin
        out_pix = s1_pix;
        if (s1_roi) begin
            for (int c = 0; c < NCH; c++) begin
                case (s1_mode)
                    MODE_BIN:  out_pix[c*CW +: CW] = {CW{s1_gt0[c]}};
                    MODE_INV:  out_pix[c*CW +: CW] = {CW{~s1_gt0[c]}};
                    MODE_BAND: out_pix[c*CW +: CW] = {CW{s1_gt0[c] & ~s1_gt1[c]}};
                    default:   out_pix[c*CW +: CW] = s1_lvl[c];
                endcase
            end
        end
    end

    // Output register; data holds its last value between valid pixels.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_vld  <= 1'b0;
            out_sof  <= 1'b0;
            out_eol  <= 1'b0;
            out_data <= '0;
        end else begin
            out_vld <= s1_vld;
            out_sof <= s1_sof;
            out_eol <= s1_eol;
            if (s1_vld) out_data <= out_pix;
        end
    end

    assign pix.d_out     = out_data;
    assign pix.d_out_vld = out_vld;
    assign pix.d_out_sof = out_sof;
    assign pix.d_out_eol = out_eol;

endmodule

// File: tb/tb_threshold_multi.sv
// tb_threshold_multi: directed test of threshold_multi with a 4x2 frame.
// Covers binary, multi-level, band, commit timing, gapped valid, reset and
// (when THRESHOLD_ROI_EN is defined) the ROI window.
module tb_threshold_multi;
    localparam int CW   = 8;
    localparam int NCH  = 3;
    localparam int NLVL = 4;
    localparam int AW   = $clog2(NLVL + 1);
    localparam int PW   = NCH * CW;
    localparam int NBUF = 32;

    logic clk = 1'b0;
    logic reset;
    logic [15:0] input_res_x, input_res_y;
    logic threshold_set, threshold_t;
    logic [AW-1:0] threshold_a;
    logic [NCH-1:0] threshold_c;
    logic [PW-1:0] threshold_v;
    logic [1:0] mode;
    logic commit;
`ifdef THRESHOLD_ROI_EN
    logic [15:0] roi_x0, roi_x1, roi_y0, roi_y1;
`endif

    threshold_multi_if #(.CW(CW), .NCH(NCH)) bus();

    threshold_multi #(.CW(CW), .NCH(NCH), .NLVL(NLVL)) dut (
        .clk(clk),
        .reset(reset),
        .pix(bus),
        .input_res_x(input_res_x),
        .input_res_y(input_res_y),
        .threshold_set(threshold_set),
        .threshold_t(threshold_t),
        .threshold_a(threshold_a),
        .threshold_c(threshold_c),
        .threshold_v(threshold_v),
        .mode(mode),
        .commit(commit)
`ifdef THRESHOLD_ROI_EN
        ,
        .roi_x0(roi_x0),
        .roi_x1(roi_x1),
        .roi_y0(roi_y0),
        .roi_y1(roi_y1)
`endif
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int out_idx;
    logic [PW-1:0] stim_pix [NBUF];
    logic [PW-1:0] exp_pix  [NBUF];
    logic [PW-1:0] stim_val [NBUF];
    bit            stim_set [NBUF];
    bit            stim_cmt [NBUF];
    bit            exp_sof  [NBUF];
    bit            exp_eol  [NBUF];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Pixel i of a 4x2 frame stream starting at the origin.
    task automatic setPix(input int i, input logic [PW-1:0] stim, input logic [PW-1:0] expv);
        stim_pix[i] = stim;
        exp_pix[i]  = expv;
        exp_sof[i]  = (i % 8 == 0);
        exp_eol[i]  = (i % 4 == 3);
    endtask

    task automatic clearStim();
        for (int i = 0; i < NBUF; i++) begin
            stim_set[i] = 1'b0;
            stim_cmt[i] = 1'b0;
            stim_val[i] = '0;
        end
    endtask

    task automatic writeTable(input logic t, input logic [AW-1:0] a, input logic [NCH-1:0] c, input logic [PW-1:0] v);
        threshold_set = 1'b1;
        threshold_t   = t;
        threshold_a   = a;
        threshold_c   = c;
        threshold_v   = v;
        @(posedge clk); #1;
        threshold_set = 1'b0;
    endtask

    task automatic pulseCommit();
        commit = 1'b1;
        @(posedge clk); #1;
        commit = 1'b0;
    endtask

    task automatic collectOutput(input string tag, input int n);
        if (bus.d_out_vld) begin
            if (out_idx < n) begin
                checkOutput($sformatf("%s.pix%0d", tag, out_idx), 32'(bus.d_out), 32'(exp_pix[out_idx]));
                checkOutput($sformatf("%s.sof%0d", tag, out_idx), 32'(bus.d_out_sof), 32'(exp_sof[out_idx]));
                checkOutput($sformatf("%s.eol%0d", tag, out_idx), 32'(bus.d_out_eol), 32'(exp_eol[out_idx]));
            end else begin
                checkOutput($sformatf("%s.extra_vld", tag), 32'(bus.d_out_vld), 32'd0);
            end
            out_idx++;
        end
    endtask

    task automatic applyStimulus(input string tag, input int n, input int max_gap);
        int cyc;
        cyc = 0;
        out_idx = 0;
        for (int i = 0; i < n; i++) begin
            if (max_gap > 0) begin
                int gap;
                gap = int'($urandom_range(max_gap, 0));
                for (int g = 0; g < gap; g++) begin
                    bus.d_in_vld  = 1'b0;
                    threshold_set = 1'b0;
                    commit        = 1'b0;
                    @(posedge clk); #1;
                    collectOutput(tag, n);
                end
            end
            bus.d_in      = stim_pix[i];
            bus.d_in_vld  = 1'b1;
            threshold_set = stim_set[i];
            threshold_t   = 1'b0;
            threshold_a   = '0;
            threshold_c   = '1;
            threshold_v   = stim_val[i];
            commit        = stim_cmt[i];
            @(posedge clk); #1;
            if (max_gap == 0)
                checkOutput($sformatf("%s.vld_cyc%0d", tag, cyc), 32'(bus.d_out_vld), 32'(cyc >= 1));
            collectOutput(tag, n);
            cyc++;
        end
        bus.d_in_vld  = 1'b0;
        threshold_set = 1'b0;
        commit        = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (max_gap == 0)
                checkOutput($sformatf("%s.vld_cyc%0d", tag, cyc), 32'(bus.d_out_vld), 32'(cyc <= n));
            collectOutput(tag, n);
            cyc++;
        end
        checkOutput($sformatf("%s.count", tag), 32'(out_idx), 32'(n));
        clearStim();
    endtask

    // Bound on total run time in case the bench stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    // Directed sequence of all scenarios.
    initial begin
        reset = 1'b1;
        bus.d_in = '0;
        bus.d_in_vld = 1'b0;
        input_res_x = 16'd4;
        input_res_y = 16'd2;
        threshold_set = 1'b0;
        threshold_t = 1'b0;
        threshold_a = '0;
        threshold_c = '0;
        threshold_v = '0;
        mode = 2'd0;
        commit = 1'b0;
`ifdef THRESHOLD_ROI_EN
        roi_x0 = 16'd0;
        roi_x1 = 16'hFFFF;
        roi_y0 = 16'd0;
        roi_y1 = 16'hFFFF;
`endif
        clearStim();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.d_out", 32'(bus.d_out), 32'h0);
        checkOutput("reset.vld", 32'(bus.d_out_vld), 32'h0);
        checkOutput("reset.sof", 32'(bus.d_out_sof), 32'h0);
        checkOutput("reset.eol", 32'(bus.d_out_eol), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] binary mode");
        writeTable(1'b0, 3'd0, 3'b111, 24'h808080);
        mode = 2'd0;
        pulseCommit();
        setPix(0, 24'h81807F, 24'hFF0000);
        setPix(1, 24'h00FF80, 24'h00FF00);
        setPix(2, 24'hFFFFFF, 24'hFFFFFF);
        setPix(3, 24'h000000, 24'h000000);
        setPix(4, 24'h7F8081, 24'h0000FF);
        setPix(5, 24'h818181, 24'hFFFFFF);
        setPix(6, 24'h808080, 24'h000000);
        setPix(7, 24'h10F010, 24'h00FF00);
        applyStimulus("bin", 8, 0);
        checkOutput("hold.d_out", 32'(bus.d_out), 32'h00FF00);

        $display("[TB] multi-level mode");
        writeTable(1'b0, 3'd0, 3'b001, 24'h000040);
        writeTable(1'b0, 3'd1, 3'b001, 24'h000080);
        writeTable(1'b0, 3'd2, 3'b001, 24'h0000C0);
        writeTable(1'b0, 3'd3, 3'b001, 24'h0000F0);
        writeTable(1'b0, 3'd4, 3'b111, 24'hFFFFFF);
        writeTable(1'b1, 3'd0, 3'b001, 24'h000000);
        writeTable(1'b1, 3'd1, 3'b001, 24'h000040);
        writeTable(1'b1, 3'd2, 3'b001, 24'h000080);
        writeTable(1'b1, 3'd3, 3'b001, 24'h0000C0);
        writeTable(1'b1, 3'd4, 3'b001, 24'h0000FF);
        mode = 2'd3;
        pulseCommit();
        setPix(0, 24'hABCD10, 24'h000000);
        setPix(1, 24'hABCD90, 24'h000080);
        setPix(2, 24'hABCDFF, 24'h0000FF);
        setPix(3, 24'hABCD40, 24'h000000);
        setPix(4, 24'hABCD41, 24'h000040);
        setPix(5, 24'hABCDF0, 24'h0000C0);
        setPix(6, 24'hABCDC1, 24'h0000C0);
        setPix(7, 24'hABCD80, 24'h000040);
        applyStimulus("multi", 8, 0);

        $display("[TB] band mode");
        writeTable(1'b0, 3'd0, 3'b111, 24'h202020);
        writeTable(1'b0, 3'd1, 3'b111, 24'h606060);
        mode = 2'd2;
        pulseCommit();
        setPix(0, 24'h202020, 24'h000000);
        setPix(1, 24'h212121, 24'hFFFFFF);
        setPix(2, 24'h606060, 24'hFFFFFF);
        setPix(3, 24'h616161, 24'h000000);
        setPix(4, 24'h00FF40, 24'h0000FF);
        setPix(5, 24'h602161, 24'hFFFF00);
        setPix(6, 24'h000000, 24'h000000);
        setPix(7, 24'h5F1F30, 24'hFF00FF);
        applyStimulus("band", 8, 0);

        $display("[TB] band with inverted thresholds");
        writeTable(1'b0, 3'd1, 3'b111, 24'h101010);
        pulseCommit();
        setPix(0, 24'h151515, 24'h000000);
        setPix(1, 24'h252525, 24'h000000);
        setPix(2, 24'hFFFFFF, 24'h000000);
        setPix(3, 24'h000000, 24'h000000);
        setPix(4, 24'h201020, 24'h000000);
        setPix(5, 24'h111111, 24'h000000);
        setPix(6, 24'h1F2122, 24'h000000);
        setPix(7, 24'h808080, 24'h000000);
        applyStimulus("band_inv", 8, 0);

        $display("[TB] commit timing");
        mode = 2'd0;
        writeTable(1'b0, 3'd0, 3'b111, 24'h808080);
        pulseCommit();
        for (int i = 0; i < 32; i++)
            setPix(i, 24'h606060, (i >= 8 && i < 24) ? 24'hFFFFFF : 24'h000000);
        stim_set[5]  = 1'b1;
        stim_val[5]  = 24'h404040;
        stim_cmt[5]  = 1'b1;
        stim_set[12] = 1'b1;
        stim_val[12] = 24'h707070;
        stim_cmt[16] = 1'b1;
        applyStimulus("commit", 32, 0);

        $display("[TB] gapped valid");
        setPix(0,  24'h718000, 24'hFFFF00);
        setPix(1,  24'h70FF71, 24'h00FFFF);
        setPix(2,  24'h000000, 24'h000000);
        setPix(3,  24'hFFFFFF, 24'hFFFFFF);
        setPix(4,  24'h717171, 24'hFFFFFF);
        setPix(5,  24'h707070, 24'h000000);
        setPix(6,  24'h10F020, 24'h00FF00);
        setPix(7,  24'h9000A0, 24'hFF00FF);
        setPix(8,  24'h01FE02, 24'h00FF00);
        setPix(9,  24'h800000, 24'hFF0000);
        setPix(10, 24'h000080, 24'h0000FF);
        setPix(11, 24'h7F6F7F, 24'hFF00FF);
        applyStimulus("gap", 12, 2);

        $display("[TB] reset mid-line");
        bus.d_in = 24'h818181;
        bus.d_in_vld = 1'b1;
        @(posedge clk); #1;
        bus.d_in_vld = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst.d_out", 32'(bus.d_out), 32'h0);
        checkOutput("midrst.vld", 32'(bus.d_out_vld), 32'h0);
        checkOutput("midrst.sof", 32'(bus.d_out_sof), 32'h0);
        checkOutput("midrst.eol", 32'(bus.d_out_eol), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("midrst.flushed_vld", 32'(bus.d_out_vld), 32'h0);
        setPix(0, 24'h810000, 24'hFF0000);
`ifdef THRESHOLD_ROI_EN
        setPix(1, 24'h000001, 24'h000001);
`else
        setPix(1, 24'h000001, 24'h0000FF);
`endif
        applyStimulus("postrst", 2, 0);

`ifdef THRESHOLD_ROI_EN
        $display("[TB] ROI window");
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        roi_x0 = 16'd1;
        roi_x1 = 16'd2;
        roi_y0 = 16'd0;
        roi_y1 = 16'd0;
        writeTable(1'b0, 3'd0, 3'b111, 24'h808080);
        mode = 2'd0;
        pulseCommit();
        for (int i = 0; i < 8; i++)
            setPix(i, 24'h101010, (i == 1 || i == 2) ? 24'h000000 : 24'h101010);
        applyStimulus("roi", 8, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
